fft_peak_detect: RTL and testbench
==================================

Name: fft_peak_detect

Overview:
- Sits directly downstream of the FFT core's source-side stream, consuming one complex bin per valid beat.
- For each frame it computes per-bin power (re² + im²) over the non-mirrored half-spectrum and tracks the maximum.
- At frame end it reports peak bin index, peak power and the frame's block exponent, giving the system a dominant-frequency measurement.
- It also flags malformed frames (bad sop/eop framing).

Parameters:
- DW, 12, width of signed real/imag input samples.
- N, 1024, FFT length in bins; power of two.
- IDXW, 10, bin index width, equal to log2(N).
- SKIP_DC, 1, when 1 bin 0 is excluded from the peak search.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid; this block is always ready.
- in_sop  input  1  first bin of frame, qualified by in_valid.
- in_eop  input  1  last bin of frame, qualified by in_valid.
- in_real  input  DW  signed real part, two's complement.
- in_imag  input  DW  signed imaginary part.
- in_exp  input  6  block exponent, sampled on the sop beat.
- peak_valid  output  1  one-cycle pulse when a frame result is presented.
- peak_bin  output  IDXW  bin index of maximum power.
- peak_pwr  output  2*DW+1  unsigned power of the peak bin.
- peak_exp  output  6  exponent latched at the frame's sop.
- frame_err  output  1  one-cycle pulse on malformed frame.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, bin counter 0, running max 0, pipeline valids cleared. A reset mid-frame discards the partial frame; no peak_valid and no frame_err are produced for it.
- FSM has two states, IDLE and ACCUM.
- IDLE behaviour:
  - in_valid and in_sop together: bin counter = 0, latch in_exp, clear running max, enter ACCUM; that beat is bin 0.
  - in_valid without in_sop: beat ignored.
- ACCUM behaviour:
  - Each in_valid beat advances the bin counter by 1.
  - in_valid and in_eop with counter == N-1: frame good; return to IDLE and schedule the result.
  - in_valid and in_eop with counter != N-1: frame_err pulse, no result, return to IDLE.
  - in_valid and in_sop while in ACCUM: abandon the current frame, pulse frame_err, and restart. The beat is taken as bin 0 of a new frame (exp latched, max cleared, stay in ACCUM).
  - Counter reaching N-1 without in_eop: on the next beat (count wraps), pulse frame_err and go to IDLE; that beat is ignored unless it carries in_sop, which is handled as a sop from IDLE.
  - Gaps (in_valid low) in any state: hold all state.
- Power pipeline:
  - Stage 1 registers re*re and im*im, each as 2*DW-bit unsigned (squares are non-negative).
  - Stage 2 registers the sum as 2*DW+1 bits; no overflow is possible (max 2^(2DW-1)).
  - Stage 3 performs the compare/update.
  - Bin index and a "candidate" flag travel alongside the data through the pipeline.
- Candidate bins: 0 ≤ k < N/2, with k = 0 excluded when SKIP_DC = 1.
- Max update: a candidate replaces the running max only if its power is strictly greater. Ties keep the lowest index. An all-zero frame reports bin (SKIP_DC ? 1 : 0) with pwr 0.
- Latency: peak_valid asserts exactly 3 cycles after the clock edge that accepts the good eop beat. peak_bin, peak_pwr and peak_exp are valid in that cycle and hold until the next result or reset.
- A new sop accepted during the 3-cycle drain must not corrupt the pending result: the pipeline carries a frame tag or a separate result register is used. A back-to-back frame with zero idle cycles is supported.
- frame_err is asserted in the cycle after the offending beat.

Test Plan:
- N=1024, SKIP_DC=1, all bins 0 except bin 37 = (100, -50), exp=5 -> peak_valid 3 cycles after eop; peak_bin=37, peak_pwr=12500, peak_exp=5.
- Bin 987 = (500, 0) and bin 37 = (100, -50), all others 0 -> peak_bin=37 (mirror half ignored). Bin 0 = (2047, 0) with SKIP_DC=1 is likewise ignored.
- Bins 10 and 20 both = (-2048, -2048) -> peak_bin=10, peak_pwr=8388608 (full-scale, no overflow).
- eop asserted on bin 500; separately, sop re-asserted at bin 300 -> frame_err pulse each time, no peak_valid. The restarted frame with a tone at bin 3 yields peak_bin=3.
- Two frames back-to-back, no gap: tones at bin 5 then bin 9, with in_valid gaps inserted inside frame 2 -> two peak_valid pulses reporting 5 then 9.
- rst_n low at bin 400, then a clean frame with a tone at bin 64 -> no output for the aborted frame; next result peak_bin=64, and all outputs read 0 during reset.

Source files
------------

// File: rtl/fft_peak_detect.sv
// ---------------------------------------------------------------------------
// fft_peak_detect
//
// Consumes the FFT source-side stream one complex bin per valid beat, computes
// per-bin power (re^2 + im^2) over the non-mirrored half spectrum and reports
// the strongest bin once per well-formed frame.
//
// The frame exponent travels down the pipeline with the first beat and the
// running maximum is only cleared when that beat reaches the compare stage.
// A frame that starts right behind a finishing one therefore never disturbs
// the result that is still draining.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   beat valid (block is always ready)
//   in_sop     in   first bin of frame
//   in_eop     in   last bin of frame
//   in_real    in   signed real part, DW bits
//   in_imag    in   signed imaginary part, DW bits
//   in_exp     in   block exponent, taken on the sop beat
//   peak_valid out  one-cycle pulse, frame result presented
//   peak_bin   out  index of the maximum-power bin
//   peak_pwr   out  power of that bin, unsigned 2*DW+1 bits
//   peak_exp   out  exponent of the frame
//   frame_err  out  one-cycle pulse on a malformed frame
// ---------------------------------------------------------------------------
module fft_peak_detect #(
    parameter int DW      = 12,
    parameter int N       = 1024,
    parameter int IDXW    = 10,
    parameter int SKIP_DC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    input  logic [5:0]           in_exp,
    output logic                 peak_valid,
    output logic [IDXW-1:0]      peak_bin,
    output logic [2*DW:0]        peak_pwr,
    output logic [5:0]           peak_exp,
    output logic                 frame_err
);

    localparam logic [IDXW-1:0] LAST_BIN = IDXW'(N - 1);
    // Reported when no candidate bin beats zero power.
    localparam logic [IDXW-1:0] DEF_BIN  = (SKIP_DC != 0) ? IDXW'(1) : '0;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [2*DW-1:0] square(input logic signed [DW-1:0] x);
        logic signed [2*DW-1:0] p;
        p = x * x;
        return p;
    endfunction

    // Sum of two squares cannot overflow 2*DW+1 bits.
    function automatic logic [2*DW:0] add_pwr(input logic [2*DW-1:0] a,
                                              input logic [2*DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Lower half of the spectrum only, optionally without DC.
    function automatic logic is_cand(input logic [IDXW-1:0] k);
        return !k[IDXW-1] && !((SKIP_DC != 0) && (k == '0));
    endfunction

    // -----------------------------------------------------------------------
    // Framing FSM
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] cnt_nxt;
    logic            err_d;
    logic            push_d;
    logic [IDXW-1:0] bin_d;
    logic            first_d;
    logic            last_d;

    assign cnt_nxt = cnt_q + IDXW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        push_d  = 1'b0;
        bin_d   = cnt_q;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                // A sop always opens a new frame at bin 0; in ACCUM it also
                // abandons the frame in progress. sop+eop together is a
                // one-beat frame, which can never be complete.
                err_d   = (state_q == ACCUM) || in_eop;
                push_d  = 1'b1;
                bin_d   = '0;
                first_d = 1'b1;
                cnt_d   = '0;
                state_d = in_eop ? IDLE : ACCUM;
            end else if (state_q == ACCUM) begin
                if (cnt_q == LAST_BIN) begin
                    // Frame ran past N bins without an eop.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    push_d = 1'b1;
                    bin_d  = cnt_nxt;
                    cnt_d  = cnt_nxt;
                    if (in_eop) begin
                        state_d = IDLE;
                        if (cnt_nxt == LAST_BIN) begin
                            last_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: squares
    // -----------------------------------------------------------------------
    logic            vld_p1_q, first_p1_q, last_p1_q;
    logic [2*DW-1:0] re_sq_p1_q, im_sq_p1_q;
    logic [IDXW-1:0] bin_p1_q;
    logic            cand_p1_q;
    logic [5:0]      exp_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
        end else begin
            vld_p1_q   <= push_d;
            first_p1_q <= first_d;
            last_p1_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_d) begin
            re_sq_p1_q <= square(in_real);
            im_sq_p1_q <= square(in_imag);
            bin_p1_q   <= bin_d;
            cand_p1_q  <= is_cand(bin_d);
            exp_p1_q   <= in_exp;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: power sum
    // -----------------------------------------------------------------------
    logic            vld_p2_q, first_p2_q, last_p2_q;
    logic [2*DW:0]   pwr_p2_q;
    logic [IDXW-1:0] bin_p2_q;
    logic            cand_p2_q;
    logic [5:0]      exp_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q   <= 1'b0;
            first_p2_q <= 1'b0;
            last_p2_q  <= 1'b0;
        end else begin
            vld_p2_q   <= vld_p1_q;
            first_p2_q <= first_p1_q;
            last_p2_q  <= last_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            pwr_p2_q  <= add_pwr(re_sq_p1_q, im_sq_p1_q);
            bin_p2_q  <= bin_p1_q;
            cand_p2_q <= cand_p1_q;
            exp_p2_q  <= exp_p1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: running maximum
    // -----------------------------------------------------------------------
    logic [2*DW:0]   run_pwr_q, run_pwr_d;
    logic [IDXW-1:0] run_bin_q, run_bin_d;
    logic [5:0]      run_exp_q, run_exp_d;
    logic            done_p3_q;

    always_comb begin
        run_pwr_d = run_pwr_q;
        run_bin_d = run_bin_q;
        run_exp_d = run_exp_q;
        if (vld_p2_q) begin
            if (first_p2_q) begin
                run_exp_d = exp_p2_q;
                if (cand_p2_q) begin
                    run_pwr_d = pwr_p2_q;
                    run_bin_d = bin_p2_q;
                end else begin
                    run_pwr_d = '0;
                    run_bin_d = DEF_BIN;
                end
            end else if (cand_p2_q && (pwr_p2_q > run_pwr_q)) begin
                // Strictly greater: ties keep the earlier (lower) bin.
                run_pwr_d = pwr_p2_q;
                run_bin_d = bin_p2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_pwr_q <= '0;
            run_bin_q <= '0;
            run_exp_q <= '0;
            done_p3_q <= 1'b0;
        end else begin
            run_pwr_q <= run_pwr_d;
            run_bin_q <= run_bin_d;
            run_exp_q <= run_exp_d;
            done_p3_q <= vld_p2_q && last_p2_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic            peak_valid_q;
    logic [IDXW-1:0] peak_bin_q;
    logic [2*DW:0]   peak_pwr_q;
    logic [5:0]      peak_exp_q;
    logic            frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pwr_q   <= '0;
            peak_exp_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            peak_valid_q <= done_p3_q;
            frame_err_q  <= err_d;
            if (done_p3_q) begin
                peak_bin_q <= run_bin_q;
                peak_pwr_q <= run_pwr_q;
                peak_exp_q <= run_exp_q;
            end
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_bin   = peak_bin_q;
    assign peak_pwr   = peak_pwr_q;
    assign peak_exp   = peak_exp_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

    localparam int DW   = 12;
    localparam int N    = 1024;
    localparam int IDXW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_sop, in_eop;
    logic signed [DW-1:0] in_real, in_imag;
    logic [5:0]           in_exp;
    logic                 peak_valid;
    logic [IDXW-1:0]      peak_bin;
    logic [2*DW:0]        peak_pwr;
    logic [5:0]           peak_exp;
    logic                 frame_err;

    fft_peak_detect #(.DW(DW), .N(N), .IDXW(IDXW), .SKIP_DC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_pwr(peak_pwr),
        .peak_exp(peak_exp), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     bin;
        longint pwr;
        int     ex;
        int     cyc;
    } res_t;

    res_t   rq[$];
    int     cyc = 0;
    int     err_cnt = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     re_a[N];
    int     im_a[N];

    always @(posedge clk) cyc <= cyc + 1;

    // Record results and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n && peak_valid) begin
            rq.push_back('{bin: int'(peak_bin), pwr: longint'(peak_pwr),
                           ex: int'(peak_exp), cyc: cyc});
        end
        if (rst_n && frame_err) err_cnt = err_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_bins();
        for (int i = 0; i < N; i++) begin
            re_a[i] = 0;
            im_a[i] = 0;
        end
    endtask

    task automatic beat(input bit sop, input bit eop, input int re, input int im, input int ex);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_real  = DW'(re);
        in_imag  = DW'(im);
        in_exp   = 6'(ex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic send_frame(input int nb, input bit with_eop, input int gap_every,
                              input int ex, output int eop_cyc);
        eop_cyc = -1;
        for (int i = 0; i < nb; i++) begin
            if (gap_every > 0 && i > 0 && (i % gap_every) == 0) idle(2);
            beat(i == 0, with_eop && (i == nb - 1), re_a[i % N], im_a[i % N], ex);
            if (i == nb - 1) eop_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_real = '0; in_imag = '0; in_exp = '0;
        idle(3);
        n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d want 0", peak_valid); end
        n_checks++; if (peak_bin !== '0) begin n_fail++; $display("FAIL reset_bin got %0d want 0", peak_bin); end
        n_checks++; if (peak_pwr !== '0) begin n_fail++; $display("FAIL reset_pwr got %0d want 0", peak_pwr); end
        n_checks++; if (peak_exp !== '0) begin n_fail++; $display("FAIL reset_exp got %0d want 0", peak_exp); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0d want 0", frame_err); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_tone();
        int e, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[37] = 100; im_a[37] = -50;
        send_frame(N, 1, 0, 5, e);
        idle(8);
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL tone_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 37) begin n_fail++; $display("FAIL tone_bin got %0d want 37", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd12500) begin n_fail++; $display("FAIL tone_pwr got %0d want 12500", rq[0].pwr); end
            n_checks++; if (rq[0].ex !== 5) begin n_fail++; $display("FAIL tone_exp got %0d want 5", rq[0].ex); end
            n_checks++; if (rq[0].cyc - e !== 3) begin n_fail++; $display("FAIL tone_latency got %0d want 3", rq[0].cyc - e); end
        end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL tone_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_mirror_dc();
        int e;
        clear_bins(); rq.delete();
        re_a[987] = 500;
        re_a[37]  = 100; im_a[37] = -50;
        re_a[0]   = 2047;
        send_frame(N, 1, 0, 9, e);
        idle(8);
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL mirror_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 37) begin n_fail++; $display("FAIL mirror_bin got %0d want 37", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd12500) begin n_fail++; $display("FAIL mirror_pwr got %0d want 12500", rq[0].pwr); end
        end
    endtask

    task automatic test_full_scale_tie();
        int e;
        clear_bins(); rq.delete();
        re_a[10] = -2048; im_a[10] = -2048;
        re_a[20] = -2048; im_a[20] = -2048;
        send_frame(N, 1, 0, 1, e);
        idle(8);
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL fs_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 10) begin n_fail++; $display("FAIL fs_bin got %0d want 10", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd8388608) begin n_fail++; $display("FAIL fs_pwr got %0d want 8388608", rq[0].pwr); end
        end
    endtask

    task automatic test_all_zero();
        int e;
        clear_bins(); rq.delete();
        send_frame(N, 1, 0, 3, e);
        idle(8);
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL zero_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 1) begin n_fail++; $display("FAIL zero_bin got %0d want 1", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd0) begin n_fail++; $display("FAIL zero_pwr got %0d want 0", rq[0].pwr); end
            n_checks++; if (rq[0].ex !== 3) begin n_fail++; $display("FAIL zero_exp got %0d want 3", rq[0].ex); end
        end
    endtask

    task automatic test_bad_eop();
        int e, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[37] = 100;
        send_frame(501, 1, 0, 4, e);
        idle(8);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL badeop_err got %0d want 1", err_cnt - e0); end
        n_checks++; if (rq.size() !== 0) begin n_fail++; $display("FAIL badeop_count got %0d want 0", rq.size()); end
    endtask

    task automatic test_sop_restart();
        int e, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[3] = 7;
        send_frame(300, 0, 0, 6, e);
        send_frame(N, 1, 0, 2, e);
        idle(8);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL restart_err got %0d want 1", err_cnt - e0); end
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL restart_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 3) begin n_fail++; $display("FAIL restart_bin got %0d want 3", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd49) begin n_fail++; $display("FAIL restart_pwr got %0d want 49", rq[0].pwr); end
            n_checks++; if (rq[0].ex !== 2) begin n_fail++; $display("FAIL restart_exp got %0d want 2", rq[0].ex); end
        end
    endtask

    task automatic test_wrap();
        int e, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[50] = 20;
        send_frame(N + 1, 0, 0, 8, e);
        idle(8);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL wrap_err got %0d want 1", err_cnt - e0); end
        n_checks++; if (rq.size() !== 0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", rq.size()); end
    endtask

    task automatic test_back_to_back();
        int e1, e2, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[5] = 30; im_a[5] = 40;
        send_frame(N, 1, 0, 1, e1);
        re_a[5] = 0; im_a[5] = 0;
        re_a[9] = 3; im_a[9] = 4;
        send_frame(N, 1, 100, 2, e2);
        idle(8);
        n_checks++; if (rq.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", rq.size()); end
        if (rq.size() == 2) begin
            n_checks++; if (rq[0].bin !== 5) begin n_fail++; $display("FAIL b2b_bin0 got %0d want 5", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd2500) begin n_fail++; $display("FAIL b2b_pwr0 got %0d want 2500", rq[0].pwr); end
            n_checks++; if (rq[0].ex !== 1) begin n_fail++; $display("FAIL b2b_exp0 got %0d want 1", rq[0].ex); end
            n_checks++; if (rq[0].cyc - e1 !== 3) begin n_fail++; $display("FAIL b2b_lat0 got %0d want 3", rq[0].cyc - e1); end
            n_checks++; if (rq[1].bin !== 9) begin n_fail++; $display("FAIL b2b_bin1 got %0d want 9", rq[1].bin); end
            n_checks++; if (rq[1].pwr !== 64'd25) begin n_fail++; $display("FAIL b2b_pwr1 got %0d want 25", rq[1].pwr); end
            n_checks++; if (rq[1].ex !== 2) begin n_fail++; $display("FAIL b2b_exp1 got %0d want 2", rq[1].ex); end
            n_checks++; if (rq[1].cyc - e2 !== 3) begin n_fail++; $display("FAIL b2b_lat1 got %0d want 3", rq[1].cyc - e2); end
        end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_reset_midframe();
        int e, e0;
        clear_bins(); rq.delete(); e0 = err_cnt;
        re_a[200] = 1000;
        send_frame(400, 0, 0, 11, e);
        rst_n = 1'b0;
        #1;
        n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0d want 0", peak_valid); end
        n_checks++; if (peak_bin !== '0) begin n_fail++; $display("FAIL midrst_bin got %0d want 0", peak_bin); end
        n_checks++; if (peak_pwr !== '0) begin n_fail++; $display("FAIL midrst_pwr got %0d want 0", peak_pwr); end
        n_checks++; if (peak_exp !== '0) begin n_fail++; $display("FAIL midrst_exp got %0d want 0", peak_exp); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %0d want 0", frame_err); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clear_bins();
        re_a[64] = 0; im_a[64] = -9;
        send_frame(N, 1, 0, 7, e);
        idle(8);
        n_checks++; if (rq.size() !== 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_checks++; if (rq[0].bin !== 64) begin n_fail++; $display("FAIL midrst_bin64 got %0d want 64", rq[0].bin); end
            n_checks++; if (rq[0].pwr !== 64'd81) begin n_fail++; $display("FAIL midrst_pwr81 got %0d want 81", rq[0].pwr); end
            n_checks++; if (rq[0].ex !== 7) begin n_fail++; $display("FAIL midrst_exp7 got %0d want 7", rq[0].ex); end
        end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_errcnt got %0d want 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_mirror_dc();
        test_full_scale_tie();
        test_all_zero();
        test_bad_eop();
        test_sop_restart();
        test_wrap();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
